// File: rtl/membus_arbiter_if.sv
// Shared data-memory/device bus bundle: two requesting masters on one side,
// the single device port on the other, with the arbiter in between.
interface membus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              s_read;
  logic              s_write;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;

  // Arbiter view: it serves both masters' requests and drives the device strobes.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  s_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output s_read, s_write, s_addr, s_wdata
  );

  // Surroundings view: the requesting masters plus the device answering reads.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output s_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  s_read, s_write, s_addr, s_wdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// Round-robin arbiter sharing one data-memory/device bus between the CPU MEM
// stage (master 0) and the UART loader/debug port (master 1).
module membus_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  membus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

  owner_e            r_owner;
  logic              r_last;          // 0 = master 0, 1 = master 1
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_m0_rvalid;
  logic              r_m1_rvalid;

  owner_e            w_arb_pick;
  owner_e            w_next_owner;
  logic              w_m0_gnt;
  logic              w_m1_gnt;
  logic              w_m0_read;
  logic              w_m1_read;
  logic              w_burst_done;
  logic [ADDR_W-1:0] w_s_addr;
  logic [DATA_W-1:0] w_s_wdata;

  assign w_m0_gnt     = (r_owner == OWN_M0) && bus.m0_req;
  assign w_m1_gnt     = (r_owner == OWN_M1) && bus.m1_req;
  assign w_m0_read    = w_m0_gnt && !bus.m0_we;
  assign w_m1_read    = w_m1_gnt && !bus.m1_we;
  assign w_burst_done = ({1'b0, r_cnt} + 5'd1) >= BURST_LIMIT;

  // With no grant the device bus idles on master 0's address and data.
  assign w_s_addr  = w_m1_gnt ? bus.m1_addr  : bus.m0_addr;
  assign w_s_wdata = w_m1_gnt ? bus.m1_wdata : bus.m0_wdata;

  assign bus.m0_gnt    = w_m0_gnt;
  assign bus.m1_gnt    = w_m1_gnt;
  assign bus.s_read    = w_m0_read || w_m1_read;
  assign bus.s_write   = (w_m0_gnt && bus.m0_we) || (w_m1_gnt && bus.m1_we);
  assign bus.s_addr    = w_s_addr;
  assign bus.s_wdata   = w_s_wdata;
  assign bus.m0_rvalid = r_m0_rvalid;
  assign bus.m1_rvalid = r_m1_rvalid;
  assign bus.rdata     = r_rdata;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal
    // unassigned; otherwise synthesis infers a latch.
    w_arb_pick = OWN_IDLE;
    if (bus.m0_req && bus.m1_req) w_arb_pick = r_last ? OWN_M0 : OWN_M1;
    else if (bus.m0_req)          w_arb_pick = OWN_M0;
    else if (bus.m1_req)          w_arb_pick = OWN_M1;
  end

  // A burst-limit handover parks in IDLE for the mandatory dead cycle; `last`
  // still names the outgoing master there, so a tie resolves to the waiter.
  always_comb begin
    w_next_owner = r_owner;
    case (r_owner)
      OWN_M0: begin
        if (!bus.m0_req)                       w_next_owner = w_arb_pick;
        else if (w_burst_done && bus.m1_req)   w_next_owner = OWN_IDLE;
      end
      OWN_M1: begin
        if (!bus.m1_req)                       w_next_owner = w_arb_pick;
        else if (w_burst_done && bus.m0_req)   w_next_owner = OWN_IDLE;
      end
      default:                                 w_next_owner = w_arb_pick;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_owner <= w_next_owner;
      if (w_next_owner != r_owner) begin
        r_cnt <= '0;
        if (w_next_owner == OWN_M0)      r_last <= 1'b0;
        else if (w_next_owner == OWN_M1) r_last <= 1'b1;
      end else if ((w_m0_gnt || w_m1_gnt) && (r_cnt != 4'hF)) begin
        r_cnt <= r_cnt + 4'd1;
      end
      r_m0_rvalid <= w_m0_read;
      r_m1_rvalid <= w_m1_read;
      if (w_m0_read || w_m1_read) r_rdata <= bus.s_rdata;
    end
  end
endmodule

// File: tb/tb_membus_arbiter.sv
// Self-checking bench for membus_arbiter: directed scenarios plus a randomized
// two-master run against a behavioural ownership/memory model.
module tb_membus_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  membus_arbiter #(.MAX_BURST(MAXB), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Device model: combinational read, write on the edge, back-door poke for preload.
  logic [31:0] slave_mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  assign bus.s_rdata = slave_mem[bus.s_addr[7:2]];

  always @(posedge clk) begin
    if (bus.s_write)  slave_mem[bus.s_addr[7:2]] <= bus.s_wdata;
    else if (poke_en) slave_mem[poke_idx] <= poke_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    poke_en = 1'b1; poke_idx = idx; poke_data = data;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_m0(1'b1, 1'b0, 32'h1234, 32'hCAFE);
    drive_m1(1'b1, 1'b1, 32'h5678, 32'hBEEF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.s_read, bus.s_write} !== 6'b0)
        $display("FAIL reset_ctrl c%0d: got %b expected 000000", c,
                 {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.s_read, bus.s_write});
      else n_pass++;
      n_checks++;
      if ({bus.s_addr, bus.s_wdata, bus.rdata} !== {32'h1234, 32'hCAFE, 32'h0})
        $display("FAIL reset_bus c%0d: got addr=%h wdata=%h rdata=%h expected 1234/cafe/0",
                 c, bus.s_addr, bus.s_wdata, bus.rdata);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_single_read();
    reset = 1'b1;
    poke(6'd4, 32'hDEADBEEF);
    apply_reset();
    drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.s_read} !== 2'b00)
      $display("FAIL read_c0: got gnt/s_read=%b expected 00", {bus.m0_gnt, bus.s_read});
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.s_read, bus.s_write, bus.s_addr} !== {4'b1010, 32'h10})
      $display("FAIL read_c1: got %b addr=%h expected 1010 addr=10",
               {bus.m0_gnt, bus.m1_gnt, bus.s_read, bus.s_write}, bus.s_addr);
    else n_pass++;
    tick();
    drive_m0(1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.s_read, bus.m0_gnt, bus.rdata} !== {4'b1000, 32'hDEADBEEF})
      $display("FAIL read_c2: got %b rdata=%h expected 1000 rdata=deadbeef",
               {bus.m0_rvalid, bus.m1_rvalid, bus.s_read, bus.m0_gnt}, bus.rdata);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.m0_rvalid, bus.rdata} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL read_hold: got rvalid=%b rdata=%h expected 0/deadbeef", bus.m0_rvalid, bus.rdata);
    else n_pass++;
  endtask

  task automatic test_contention();
    int exp_g [15];
    int got;
    exp_g = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 0, 0, 0, 0};
    apply_reset();
    drive_m0(1'b1, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h4, 32'h0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      got = bus.m0_gnt ? 0 : (bus.m1_gnt ? 1 : -1);
      n_checks++;
      if (got !== exp_g[c] || (bus.m0_gnt && bus.m1_gnt))
        $display("FAIL contention_gnt c%0d: got %0d (m0=%b m1=%b) expected %0d",
                 c, got, bus.m0_gnt, bus.m1_gnt, exp_g[c]);
      else n_pass++;
      n_checks++;
      if ({bus.m0_rvalid, bus.m1_rvalid} !== {c > 0 && exp_g[(c > 0) ? c - 1 : 0] == 0,
                                              c > 0 && exp_g[(c > 0) ? c - 1 : 0] == 1})
        $display("FAIL contention_rvalid c%0d: got %b", c, {bus.m0_rvalid, bus.m1_rvalid});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_m1_write_burst();
    apply_reset();
    drive_m1(1'b1, 1'b1, 32'h0, 32'h0);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      n_checks++;
      if (c == 0 || c == 11) begin
        if ({bus.m0_gnt, bus.m1_gnt, bus.s_write} !== 3'b000)
          $display("FAIL burst_idle c%0d: got %b expected 000", c, {bus.m0_gnt, bus.m1_gnt, bus.s_write});
        else n_pass++;
      end else begin
        if ({bus.m0_gnt, bus.m1_gnt, bus.s_read, bus.s_write, bus.m1_rvalid, bus.s_addr, bus.s_wdata}
            !== {5'b01010, 32'((c - 1) * 4), 32'(c - 1)})
          $display("FAIL burst_beat c%0d: got %b addr=%h wdata=%h expected 01010 addr=%h wdata=%h", c,
                   {bus.m0_gnt, bus.m1_gnt, bus.s_read, bus.s_write, bus.m1_rvalid},
                   bus.s_addr, bus.s_wdata, 32'((c - 1) * 4), 32'(c - 1));
        else n_pass++;
      end
      tick();
      if (c >= 1) drive_m1(c < 10, 1'b1, 32'(c * 4), 32'(c));
    end
  endtask

  task automatic test_drop_handover();
    logic [7:0] m0_sched;
    logic [7:0] m1_sched;
    int exp_g [8];
    int got;
    m0_sched = 8'b1100_0111;
    m1_sched = 8'b1101_1111;
    exp_g = '{-1, 0, 0, -1, 1, -1, -1, 0};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      drive_m0(m0_sched[c], 1'b0, 32'h8, 32'h0);
      drive_m1(m1_sched[c], 1'b0, 32'hC, 32'h0);
      @(negedge clk);
      got = bus.m0_gnt ? 0 : (bus.m1_gnt ? 1 : -1);
      n_checks++;
      if (got !== exp_g[c] || (bus.m0_gnt && bus.m1_gnt))
        $display("FAIL drop_gnt c%0d: got %0d expected %0d", c, got, exp_g[c]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    reset = 1'b1;
    poke(6'd5, 32'hA5A5_5A5A);
    poke(6'd6, 32'h0F0F_F0F0);
    apply_reset();
    drive_m1(1'b1, 1'b0, 32'h14, 32'h0);
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01)
      $display("FAIL midrst_beat1: got %b expected 01", {bus.m0_gnt, bus.m1_gnt});
    else n_pass++;
    tick();
    drive_m1(1'b1, 1'b0, 32'h18, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.m1_gnt, bus.m1_rvalid, bus.rdata} !== {2'b11, 32'hA5A5_5A5A})
      $display("FAIL midrst_beat2: got %b rdata=%h expected 11 a5a55a5a", {bus.m1_gnt, bus.m1_rvalid}, bus.rdata);
    else n_pass++;
    reset = 1'b1;
    drive_m0(1'b0, 1'b0, 32'h77, 32'h99);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.s_read, bus.s_write,
           bus.rdata, bus.s_addr, bus.s_wdata} !== {6'b0, 32'h0, 32'h77, 32'h99})
        $display("FAIL midrst_values c%0d: got %b rdata=%h addr=%h wdata=%h", c,
                 {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.s_read, bus.s_write},
                 bus.rdata, bus.s_addr, bus.s_wdata);
      else n_pass++;
      @(negedge clk);
    end
    tick();
    reset = 1'b0;
    drive_m0(1'b1, 1'b0, 32'h10, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00)
      $display("FAIL midrst_idle: got %b expected 00", {bus.m0_gnt, bus.m1_gnt});
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10)
      $display("FAIL midrst_tie: got %b expected 10", {bus.m0_gnt, bus.m1_gnt});
    else n_pass++;
  endtask

  task automatic test_write_then_read();
    logic [4:0] exp_flags [6];
    exp_flags = '{5'b00000, 5'b10010, 5'b00000, 5'b01100, 5'b00000, 5'b00000};
    reset = 1'b1;
    poke(6'd16, 32'h0);
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive_m0(1'b1, 1'b1, 32'h40, 32'h12345678);
        2: begin drive_m0(1'b0, 1'b0, 32'h40, 32'h0); drive_m1(1'b1, 1'b0, 32'h40, 32'h0); end
        4: drive_m1(1'b0, 1'b0, 32'h40, 32'h0);
        default: ;
      endcase
      @(negedge clk);
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.s_read, bus.s_write, bus.m0_rvalid} !== exp_flags[c] ||
          bus.m1_rvalid !== (c == 4))
        $display("FAIL wr_rd c%0d: got %b m1_rvalid=%b expected %b", c,
                 {bus.m0_gnt, bus.m1_gnt, bus.s_read, bus.s_write, bus.m0_rvalid}, bus.m1_rvalid, exp_flags[c]);
      else n_pass++;
      if (c == 4) begin
        n_checks++;
        if (bus.rdata !== 32'h12345678)
          $display("FAIL wr_rd_data: got %h expected 12345678", bus.rdata);
        else n_pass++;
      end
      tick();
    end
  endtask

  // Randomized run: masters issue and occasionally cancel beats; the model
  // predicts ownership from the rotation rules and tracks memory contents.
  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic        pend   [2];
    logic        we_q   [2];
    logic [31:0] addr_q [2];
    logic [31:0] wdata_q[2];
    int          holder, prev, beats, g, nh;
    bit          dead;
    logic        exp_rv0, exp_rv1;
    logic [31:0] exp_rdata;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      poke(6'(i), ref_mem[i]);
    end
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; we_q[k] = 1'b0; addr_q[k] = '0; wdata_q[k] = '0;
    end
    apply_reset();
    holder = -1; prev = 1; beats = 0; dead = 1'b0;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rdata = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          if ($urandom_range(15) == 0) pend[k] = 1'b0;
        end else if ($urandom_range(2) != 0) begin
          pend[k]    = 1'b1;
          we_q[k]    = 1'($urandom_range(1));
          addr_q[k]  = {26'd0, 4'($urandom_range(15)), 2'b00};
          wdata_q[k] = $urandom;
        end
      end
      drive_m0(pend[0], we_q[0], addr_q[0], wdata_q[0]);
      drive_m1(pend[1], we_q[1], addr_q[1], wdata_q[1]);
      @(negedge clk);
      g = (holder >= 0 && !dead && pend[holder]) ? holder : -1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== {g == 0, g == 1})
        $display("FAIL rnd_gnt cyc%0d: got %b expected holder %0d", cyc, {bus.m0_gnt, bus.m1_gnt}, g);
      else n_pass++;
      n_checks++;
      if ({bus.s_read, bus.s_write} !== {g >= 0 && !we_q[(g >= 0) ? g : 0], g >= 0 && we_q[(g >= 0) ? g : 0]})
        $display("FAIL rnd_strobe cyc%0d: got %b", cyc, {bus.s_read, bus.s_write});
      else n_pass++;
      n_checks++;
      if ({bus.s_addr, bus.s_wdata} !== ((g == 1) ? {addr_q[1], wdata_q[1]} : {addr_q[0], wdata_q[0]}))
        $display("FAIL rnd_sbus cyc%0d: got addr=%h wdata=%h", cyc, bus.s_addr, bus.s_wdata);
      else n_pass++;
      n_checks++;
      if ({bus.m0_rvalid, bus.m1_rvalid, bus.rdata} !== {exp_rv0, exp_rv1, exp_rdata})
        $display("FAIL rnd_read cyc%0d: got %b %h expected %b %h", cyc,
                 {bus.m0_rvalid, bus.m1_rvalid}, bus.rdata, {exp_rv0, exp_rv1}, exp_rdata);
      else n_pass++;
      exp_rv0 = (g == 0) && !we_q[0];
      exp_rv1 = (g == 1) && !we_q[1];
      if (g >= 0) begin
        if (we_q[g]) ref_mem[addr_q[g][5:2]] = wdata_q[g];
        else         exp_rdata = ref_mem[addr_q[g][5:2]];
      end
      if (holder >= 0 && pend[holder]) begin
        if (dead) dead = 1'b0;
        else begin
          beats++;
          if (beats >= MAXB && pend[1 - holder]) begin
            holder = 1 - holder; prev = holder; beats = 0; dead = 1'b1;
          end
        end
      end else begin
        dead = 1'b0;
        if (pend[0] && pend[1]) nh = 1 - prev;
        else if (pend[0])       nh = 0;
        else if (pend[1])       nh = 1;
        else                    nh = -1;
        holder = nh;
        if (nh >= 0) begin prev = nh; beats = 0; end
      end
      if (g >= 0) pend[g] = 1'b0;
      tick();
    end
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0);
    tick();
    test_reset();
    test_single_read();
    test_contention();
    test_m1_write_burst();
    test_drop_handover();
    test_reset_mid_burst();
    test_write_then_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
